// File: rtl/ssp_dual_issue_queue.sv
// -----------------------------------------------------------------------------
// ssp_dual_issue_queue
//
// Instruction queue between fetch and the two execute lanes of the superscalar
// core. Up to two instructions are accepted per cycle from fetch (NOP slots are
// compacted away on entry). Up to two instructions are issued per cycle in
// program order. The second slot is offered only when the head pair is free of
// hazards: RAW, WAW, two memory ops, or a control-flow instruction in slot 0.
//
// Ports
//   clk1        core clock (the only clock of this block)
//   reset       asynchronous, active-high reset
//   flush       synchronous discard of all entries (branch redirect)
//   in_valid    per-lane fetch valid, lane 0 is older
//   in_instr0/1 fetch lane 0/1 instruction
//   in_ready    high when at least two entries are free
//   out_valid   issue-slot valid; bit 1 is never set without bit 0
//   out_instr0  oldest queued instruction
//   out_instr1  second-oldest queued instruction
//   out_ready   execute accepts every slot flagged in out_valid this cycle
//   count       current occupancy
//
// Opcode encodings that the decode needs but that are not fixed by the ISA
// subset (LW, SW, J, JAL) are parameters so the core can match its own map.
// SW must sit inside the 011xxx group; every other 011xxx opcode is a branch.
// -----------------------------------------------------------------------------
module ssp_dual_issue_queue #(
    parameter int         DEPTH    = 8,
    parameter int         DW       = 32,
    parameter logic [5:0] NOP_OP   = 6'b111111,
    parameter logic [4:0] LINK_REG = 5'd31,
    parameter logic [5:0] LW_OP    = 6'b010000,
    parameter logic [5:0] SW_OP    = 6'b011000,
    parameter logic [5:0] J_OP     = 6'b100000,
    parameter logic [5:0] JAL_OP   = 6'b100001
) (
    input  logic                   clk1,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [1:0]             in_valid,
    input  logic [DW-1:0]          in_instr0,
    input  logic [DW-1:0]          in_instr1,
    output logic                   in_ready,
    output logic [1:0]             out_valid,
    output logic [DW-1:0]          out_instr0,
    output logic [DW-1:0]          out_instr1,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    // Register usage of one instruction; rd == 0 means "no destination",
    // which also covers writes to R0.
    typedef struct packed {
        logic       rs1_v;
        logic [4:0] rs1;
        logic       rs2_v;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       is_mem;
        logic       is_ctrl;
    } dec_t;

    // Only the opcode and the three register fields are passed in, so every
    // argument bit is meaningful.
    function automatic dec_t decode(input logic [5:0] op,
                                    input logic [4:0] f_a,
                                    input logic [4:0] f_b,
                                    input logic [4:0] f_c);
        dec_t d;
        d = '0;
        if (op[5:3] == 3'b000) begin
            // R-type
            d.rs1_v = 1'b1;
            d.rs1   = f_a;
            d.rs2_v = 1'b1;
            d.rs2   = f_b;
            d.rd    = f_c;
        end else if ((op >= 6'b001000 && op <= 6'b001100) || op == LW_OP) begin
            // I-type and LW
            d.rs1_v  = 1'b1;
            d.rs1    = f_a;
            d.rd     = f_b;
            d.is_mem = (op == LW_OP);
        end else if (op[5:3] == 3'b011) begin
            // SW and branches
            d.rs1_v   = 1'b1;
            d.rs1     = f_a;
            d.rs2_v   = 1'b1;
            d.rs2     = f_b;
            d.is_mem  = (op == SW_OP);
            d.is_ctrl = (op != SW_OP);
        end else if (op == J_OP) begin
            d.is_ctrl = 1'b1;
        end else if (op == JAL_OP) begin
            d.rd      = LINK_REG;
            d.is_ctrl = 1'b1;
        end
        return d;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];
    ptr_t          head;
    ptr_t          tail;

    // -------------------------------------------------------------------------
    // Enqueue side
    // -------------------------------------------------------------------------
    logic       keep0;
    logic       keep1;
    logic [1:0] push_n;
    ptr_t       wr_ptr1;

    assign in_ready = (count <= cnt_t'(DEPTH - 2));

    assign keep0   = in_valid[0] && (in_instr0[DW-1:DW-6] != NOP_OP);
    assign keep1   = in_valid[1] && (in_instr1[DW-1:DW-6] != NOP_OP);
    assign push_n  = in_ready ? (2'(keep0) + 2'(keep1)) : 2'd0;
    // Lane 1 lands right behind lane 0, or at tail when lane 0 was a NOP.
    assign wr_ptr1 = keep0 ? (tail + ptr_t'(1)) : tail;

    // -------------------------------------------------------------------------
    // Issue side
    // -------------------------------------------------------------------------
    dec_t       dec0;
    dec_t       dec1;
    logic       raw;
    logic       waw;
    logic       hazard;
    logic [1:0] pop_n;

    assign out_instr0 = mem[head];
    assign out_instr1 = mem[head + ptr_t'(1)];

    assign dec0 = decode(out_instr0[DW-1:DW-6], out_instr0[25:21],
                         out_instr0[20:16], out_instr0[15:11]);
    assign dec1 = decode(out_instr1[DW-1:DW-6], out_instr1[25:21],
                         out_instr1[20:16], out_instr1[15:11]);

    assign raw = (dec0.rd != 5'd0) &&
                 ((dec1.rs1_v && dec1.rs1 == dec0.rd) ||
                  (dec1.rs2_v && dec1.rs2 == dec0.rd));
    assign waw = (dec0.rd != 5'd0) && (dec0.rd == dec1.rd);

    assign hazard = raw || waw || (dec0.is_mem && dec1.is_mem) || dec0.is_ctrl;

    assign out_valid[0] = (count >= cnt_t'(1));
    assign out_valid[1] = (count >= cnt_t'(2)) && !hazard;

    // out_valid[1] implies out_valid[0], so the popcount is a simple select.
    assign pop_n = !out_ready    ? 2'd0 :
                   out_valid[1]  ? 2'd2 :
                   {1'b0, out_valid[0]};

    // -------------------------------------------------------------------------
    // Pointer and occupancy registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(pop_n);
            tail  <= tail + ptr_t'(push_n);
            count <= count + cnt_t'(push_n) - cnt_t'(pop_n);
        end
    end

    // NOTE: the entry array is deliberately left out of reset; an entry is
    // only observed once count covers it, and that is always after a write.
    always_ff @(posedge clk1) begin
        if (in_ready && !flush) begin
            if (keep0) mem[tail]    <= in_instr0;
            if (keep1) mem[wr_ptr1] <= in_instr1;
        end
    end

endmodule

// File: tb/tb_ssp_dual_issue_queue.sv
// -----------------------------------------------------------------------------
// Testbench for ssp_dual_issue_queue. A queue-based reference model decides
// occupancy, readiness, issue validity and the issued instructions from the
// architectural rules; directed scenarios are followed by randomized traffic.
// Outputs are compared on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_ssp_dual_issue_queue;

    localparam int DEPTH = 8;
    localparam int DW    = 32;

    // Opcode map used by the bench (matches the DUT parameter defaults).
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_MUL = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_AND = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd24;
    localparam logic [5:0] OP_NOP = 6'd63;

    logic                   clk1;
    logic                   reset;
    logic                   flush;
    logic [1:0]             in_valid;
    logic [DW-1:0]          in_instr0;
    logic [DW-1:0]          in_instr1;
    logic                   in_ready;
    logic [1:0]             out_valid;
    logic [DW-1:0]          out_instr0;
    logic [DW-1:0]          out_instr1;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mq[$];   // reference queue, index 0 is the oldest entry

    ssp_dual_issue_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk1       (clk1),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_instr0  (in_instr0),
        .in_instr1  (in_instr1),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_instr0 (out_instr0),
        .out_instr1 (out_instr1),
        .out_ready  (out_ready),
        .count      (count)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] op, input int rs, input int rt, input int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h1234};
    endfunction

    // Register usage from the ISA tables; -1 = no source, 0 = no dest.
    function automatic void mdec(input logic [31:0] ins, output int s1, output int s2,
                                 output int d, output bit is_mem, output bit is_ctl);
        int op;
        op = int'(ins[31:26]);
        s1 = -1; s2 = -1; d = 0; is_mem = 0; is_ctl = 0;
        if (op <= 7) begin
            s1 = int'(ins[25:21]); s2 = int'(ins[20:16]); d = int'(ins[15:11]);
        end else if ((op >= 8 && op <= 12) || op == 16) begin
            s1 = int'(ins[25:21]); d = int'(ins[20:16]); is_mem = (op == 16);
        end else if (op >= 24 && op <= 31) begin
            s1 = int'(ins[25:21]); s2 = int'(ins[20:16]);
            is_mem = (op == 24); is_ctl = (op != 24);
        end else if (op == 32) begin
            is_ctl = 1;
        end else if (op == 33) begin
            d = 31; is_ctl = 1;
        end
    endfunction

    function automatic bit pair_hazard(input logic [31:0] i0, input logic [31:0] i1);
        int a1, a2, ad, b1, b2, bd;
        bit am, ac, bm, bc;
        mdec(i0, a1, a2, ad, am, ac);
        mdec(i1, b1, b2, bd, bm, bc);
        return (ad != 0 && (b1 == ad || b2 == ad)) ||
               (ad != 0 && ad == bd) || (am && bm) || ac;
    endfunction

    function automatic logic [1:0] exp_valid();
        logic [1:0] v;
        v[0] = (mq.size() >= 1);
        v[1] = (mq.size() >= 2) && !pair_hazard(mq[0], mq[1]);
        return v;
    endfunction

    task automatic compare_all();
        logic [1:0] ev;
        ev = exp_valid();
        check("count", 64'(count), 64'(mq.size()));
        check("in_ready", 64'(in_ready), 64'(mq.size() <= DEPTH - 2));
        check("out_valid", 64'(out_valid), 64'(ev));
        if (ev[0]) check("out_instr0", 64'(out_instr0), 64'(mq[0]));
        if (ev[1]) check("out_instr1", 64'(out_instr1), 64'(mq[1]));
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl);
        logic [1:0] ev;
        int         pops;
        bit         rdy;
        in_valid  = v;
        in_instr0 = a;
        in_instr1 = b;
        out_ready = ordy;
        flush     = fl;
        ev   = exp_valid();
        rdy  = (mq.size() <= DEPTH - 2);
        pops = !ordy ? 0 : (ev[1] ? 2 : (ev[0] ? 1 : 0));
        if (fl) begin
            mq.delete();
        end else begin
            repeat (pops) void'(mq.pop_front());
            if (rdy) begin
                if (v[0] && a[31:26] != OP_NOP) mq.push_back(a);
                if (v[1] && b[31:26] != OP_NOP) mq.push_back(b);
            end
        end
        @(posedge clk1);
        @(negedge clk1);
        compare_all();
    endtask

    task automatic idle(input logic ordy);
        step(2'b00, 32'd0, 32'd0, ordy, 1'b0);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [5:0] op;
        case ($urandom_range(0, 12))
            0:  op = 6'd0;
            1:  op = 6'd1;
            2:  op = 6'd5;
            3:  op = 6'd8;
            4:  op = 6'd12;
            5:  op = 6'd16;
            6:  op = 6'd24;
            7:  op = 6'd27;
            8:  op = 6'd32;
            9:  op = 6'd33;
            10: op = 6'd13;
            11: op = 6'd63;
            default: op = 6'd2;
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 11'($urandom)};
    endfunction

    initial begin
        logic [31:0] w0, w1;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 2'b00;
        in_instr0 = '0;
        in_instr1 = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk1);
        reset = 1'b0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);

        // Independent pairs dual-issue in order.
        step(2'b11, rtype(OP_ADD, 10, 1, 20), rtype(OP_SUB, 3, 2, 21), 1'b1, 1'b0);
        check("t1_pair1_valid", 64'(out_valid), 64'd3);
        step(2'b11, rtype(OP_MUL, 4, 5, 22), rtype(OP_AND, 6, 7, 23), 1'b1, 1'b0);
        check("t1_pair2_i0", 64'(out_instr0), 64'(rtype(OP_MUL, 4, 5, 22)));
        idle(1'b1);
        check("t1_drained", 64'(count), 64'd0);

        // RAW pair issues single, then the consumer alone.
        step(2'b11, rtype(OP_ADD, 1, 2, 5), rtype(OP_SUB, 5, 3, 6), 1'b1, 1'b0);
        check("t2_raw_valid", 64'(out_valid), 64'd1);
        idle(1'b1);
        check("t2_sub_next", 64'(out_instr0), 64'(rtype(OP_SUB, 5, 3, 6)));
        idle(1'b1);
        // Two memory ops never pair.
        step(2'b11, itype(OP_LW, 1, 2), itype(OP_SW, 3, 4), 1'b1, 1'b0);
        check("t2_mem_valid", 64'(out_valid), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // NOP in lane 0 is compacted away.
        step(2'b11, {OP_NOP, 26'h155}, rtype(OP_OR, 8, 9, 24), 1'b0, 1'b0);
        check("t3_count", 64'(count), 64'd1);
        check("t3_or_head", 64'(out_instr0), 64'(rtype(OP_OR, 8, 9, 24)));
        idle(1'b1);

        // Fill to full with execute stalled, overflow push is ignored.
        for (int i = 0; i < 4; i++)
            step(2'b11, rtype(OP_ADD, 1, 2, 10 + 2 * i), rtype(OP_SUB, 3, 4, 11 + 2 * i), 1'b0, 1'b0);
        check("t4_full_count", 64'(count), 64'd8);
        check("t4_full_ready", 64'(in_ready), 64'd0);
        step(2'b11, rtype(OP_OR, 1, 1, 30), rtype(OP_OR, 2, 2, 29), 1'b0, 1'b0);
        check("t4_ignored", 64'(count), 64'd8);
        for (int i = 0; i < 4; i++) idle(1'b1);
        check("t4_drained", 64'(count), 64'd0);

        // Flush wins over a simultaneous push.
        step(2'b11, rtype(OP_ADD, 1, 2, 3), rtype(OP_ADD, 1, 2, 4), 1'b0, 1'b0);
        step(2'b11, rtype(OP_ADD, 1, 2, 5), rtype(OP_ADD, 1, 2, 6), 1'b0, 1'b0);
        step(2'b01, rtype(OP_ADD, 1, 2, 7), 32'd0, 1'b0, 1'b0);
        check("t5_five", 64'(count), 64'd5);
        step(2'b11, rtype(OP_OR, 1, 2, 8), rtype(OP_OR, 1, 2, 9), 1'b1, 1'b1);
        check("t5_flush_count", 64'(count), 64'd0);
        check("t5_flush_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges, mid-stream.
        step(2'b11, rtype(OP_ADD, 1, 2, 3), rtype(OP_ADD, 1, 2, 4), 1'b0, 1'b0);
        step(2'b11, rtype(OP_ADD, 1, 2, 5), rtype(OP_ADD, 1, 2, 6), 1'b0, 1'b0);
        in_valid = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_count", 64'(count), 64'd0);
        check("t6_async_valid", 64'(out_valid), 64'd0);
        mq.delete();
        @(posedge clk1);
        @(negedge clk1);
        reset = 1'b0;
        #1;
        compare_all();
        w0 = rtype(OP_MUL, 2, 3, 12);
        w1 = rtype(OP_AND, 4, 5, 13);
        step(2'b11, w0, w1, 1'b0, 1'b0);
        check("t6_first_push", 64'(out_instr0), 64'(w0));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(0, 3));
            step(v, rnd_instr(), rnd_instr(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 99) < 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ssp_dual_issue_queue.md
Name: ssp_dual_issue_queue

Overview:
Parametrised instruction queue between fetch and the two execute lanes of the superscalar core. Accepts up to two instructions per cycle from fetch and drops NOP slots on entry. Issues up to two instructions per cycle in program order. The second slot is issued only when the head pair carries no hazard. This replaces the fixed in-order pair fetch with buffered, hazard-aware dual issue.

Parameters:
DEPTH, 8, queue entries; power of two, at least 4
DW, 32, instruction width; opcode at [DW-1:DW-6]
NOP_OP, 6'b111111, opcode that is discarded on enqueue
LINK_REG, 5'd31, destination register written by JAL

Ports:
clk1  input  1  core clock; the block uses only this clock
reset  input  1  asynchronous, active-high reset
flush  input  1  discards all queue contents (branch redirect)
in_valid  input  2  per-lane fetch valid; lane 0 is older
in_instr0  input  DW  fetch lane 0 instruction
in_instr1  input  DW  fetch lane 1 instruction
in_ready  output  1  high when free entries >= 2
out_valid  output  2  issue-slot valid; bit 1 is never set without bit 0
out_instr0  output  DW  oldest queued instruction
out_instr1  output  DW  second-oldest queued instruction
out_ready  input  1  execute accepts every slot flagged in out_valid this cycle
count  output  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular buffer, head pointer, tail pointer and count register, all in clk1 posedge logic. Pointers wrap modulo DEPTH.
- Reset: while reset is high, head, tail and count are 0 asynchronously. Resulting outputs: out_valid=2'b00, in_ready=1, count=0. out_instr0/1 are don't-care when their valid bit is 0. Reset mid-stream loses all entries with no partial issue.
- Enqueue: happens only when in_ready=1.
  - Valid lanes whose opcode is not NOP_OP are written at tail in lane order (lane 0 first).
  - Pushed count is 0, 1 or 2. NOP lanes are compacted away.
  - When in_ready=0, inputs are ignored and fetch must hold them.
- Issue (combinational from head):
  - out_valid[0] = count>=1.
  - out_valid[1] = count>=2 AND no hazard between entries head and head+1.
  - Popped count = out_ready ? popcount(out_valid) : 0.
- Instruction decode, for hazard checks only:
  - R-type (op 000000-000111): sources rs1=[25:21], rs2=[20:16]; dest rd=[15:11].
  - I-type (001000-001100) and LW: source [25:21]; dest [20:16].
  - SW and branches (011xxx): sources [25:21] and [20:16]; no dest.
  - J: none. JAL: dest LINK_REG.
  - A dest of R0 counts as no dest.
- Hazard exists if any of the following holds:
  - RAW: I1 reads I0's dest.
  - WAW: equal non-zero dests.
  - Both instructions are memory ops (LW/SW).
  - I0 is a branch or jump.
- Same cycle: next count = count + pushed - popped. Push and pop in the same cycle are legal even when the queue is full. in_ready uses registered count only, not the same-cycle pop.
- Flush:
  - Synchronous; has priority over push and pop.
  - Next cycle: head=tail=0, count=0.
  - out_valid is not gated by flush in the flush cycle. Execute must ignore it.
- Ordering guarantee: issue order equals enqueue order. No entry is duplicated or lost across pointer wrap.

Test Plan:
1. Reset then push the pairs {ADD R10,R1->R20 ; SUB R3,R2->R21} and {MUL R4,R5->R22 ; AND R6,R7->R23} with out_ready=1 -> each pair issues with out_valid=2'b11, in order; count returns to 0.
2. Push {ADD R1,R2->R5 ; SUB R5,R3->R6} -> RAW; out_valid=2'b01, ADD issues alone, SUB issues the next cycle; a {LW ; SW} pair issues single as well.
3. Push in_valid=2'b11 with lane0=NOP and lane1=OR R8,R9->R24 -> count increments by 1 only; out_instr0 is OR.
4. out_ready=0 with 4 pairs pushed into DEPTH=8 -> count=8, in_ready=0, further pushes ignored; release out_ready -> 8 instructions issue in original order across pointer wrap.
5. Queue holds 5 entries; assert flush together with a valid push -> next cycle count=0, out_valid=0, pushed pair discarded.
6. Assert reset asynchronously mid-stream, between clk1 edges -> count=0 and out_valid=0 immediately; first push after release is issued from entry 0.
